readout_feature_quantizer: RTL and testbench
============================================

Name: readout_feature_quantizer

Overview:
- Upstream front end of the qubit-readout LogicNets classifier.
- Accepts a stream of signed I/Q ADC samples for one readout shot and integrates them into NUM_BINS time bins.
- Quantizes each of the 2*NUM_BINS bin sums to IN_BITS unsigned codes and presents the packed vector, with valid/ready, as the input word of the layer0 neuron LUTs.
- Handles shot framing, backpressure and malformed-shot reporting.

Parameters:
- SAMPLE_W, 12: signed I and Q sample width.
- WINDOW, 8: samples integrated per bin; power of two.
- NUM_BINS, 4: time bins per shot; a shot is WINDOW*NUM_BINS samples.
- IN_BITS, 2: quantized code width per feature.
- SHIFT, 12: arithmetic right shift applied to each bin sum before offset and clamp.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample accept.
- s_i  in  SAMPLE_W  signed I sample.
- s_q  in  SAMPLE_W  signed Q sample.
- s_last  in  1  final sample of a shot.
- m_valid  out  1  feature vector valid.
- m_ready  in  1  downstream accept.
- m_data  out  2*NUM_BINS*IN_BITS  packed codes. Feature 2b = I of bin b, feature 2b+1 = Q of bin b; feature k occupies m_data[k*IN_BITS +: IN_BITS].
- err_short  out  1  one-cycle pulse: shot ended early, frame discarded.
- err_long  out  1  one-cycle pulse: shot exceeded its length.

Behaviour:
- Reset values: m_valid=0, m_data=0, err_short=0, err_long=0, s_ready=0. All accumulators, sample counter and bin index clear; FSM goes to ACCUM. s_ready=1 from the first clock after reset release.
- A sample is accepted when s_valid && s_ready.
- Accumulator width is SAMPLE_W+log2(WINDOW), one I and one Q accumulator per bin, sign-extended adds (no overflow possible). The bin index advances every WINDOW accepted samples.
- FSM states:
  - ACCUM: s_ready=1. On acceptance with s_last before the WINDOW*NUM_BINS-th sample: pulse err_short, clear everything, stay in ACCUM (frame discarded). On the WINDOW*NUM_BINS-th sample: with s_last go to QUANT; without s_last pulse err_long and go to QUANT with a drain flag set.
  - QUANT: s_ready=0. Compute every code as (sum >>> SHIFT) + 2^(IN_BITS-1), clamped to [0, 2^IN_BITS-1]. Register into m_data, assert m_valid, go to HOLD.
  - HOLD: s_ready=0. m_data and m_valid held stable until m_ready. On the handshake: deassert m_valid, clear accumulators, then go to DRAIN if the drain flag is set, else ACCUM.
  - DRAIN: s_ready=1. Accepted samples are discarded. On accepted s_last go to ACCUM.
- Latency: final sample accepted in cycle N, m_valid high in cycle N+2.
- The m_ready value while m_valid=0 is ignored.
- Reset mid-shot: the frame is lost, with no error pulse.

Optional Feature:
- Macro: QUANT_ROUND_EN.
- Defined: 2^(SHIFT-1) is added to each sum before the shift (round half up).
- Undefined: truncating arithmetic shift.
- Clamp, latency and port list are identical in both builds.

Decomposition:
- Package readout_quant_pkg holds:
  - FSM state enum (ACCUM, QUANT, HOLD, DRAIN).
  - Accumulator-width and shot-length localparam functions.
  - Feature-index-to-bit-offset function.
- Sub-module quant_sat: combinational shift, optional round, offset and clamp for one feature. Instantiated 2*NUM_BINS times, with the QUANT_ROUND_EN macro inside.

Test Plan:
- Nominal: 32 samples, I=+512, Q=-512, s_last on the 32nd, m_ready=1. Response: m_data=16'h7777 two cycles after the last sample; m_valid high for one cycle; no error pulse.
- Saturation: all I=2047, Q=-2048. Response: I codes=3, Q codes=0, m_data=16'h3333.
- Backpressure: m_ready held low 10 cycles after m_valid. Response: m_data stable and s_ready=0 throughout; the handshake on cycle 11 returns to ACCUM; the next shot's first sample is then accepted.
- Short shot: s_last on sample 20. Response: err_short pulses one cycle, no m_valid. The following nominal 32-sample shot yields 16'h7777.
- Long shot: 40 samples, s_last on the 40th. Response: err_long pulses on sample 32, the frame from the first 32 samples is emitted, samples 33-40 are accepted and dropped, FSM returns to ACCUM.
- Rounding and reset: I=256 for all samples. Response: bin sum 2048 gives I code 2 without QUANT_ROUND_EN and 3 with it. Separately, rst_n pulled low at sample 15 clears all outputs, and the next full shot quantizes from zeroed sums.

Source files
------------

// File: rtl/readout_feature_quantizer_pkg.sv
// readout_quant_pkg: shared constants and helpers for the readout feature quantizer.
//   - FSM state encodings (ACCUM, QUANT, HOLD, DRAIN)
//   - acc_width(): accumulator width for a given sample width and window
//   - shot_len():  samples per shot
//   - feat_offset(): bit offset of feature k inside the packed output word
package readout_quant_pkg;

    localparam logic [1:0] StAccum = 2'd0;
    localparam logic [1:0] StQuant = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;
    localparam logic [1:0] StDrain = 2'd3;

    // Summing WINDOW samples grows the magnitude by at most log2(WINDOW) bits.
    function automatic int unsigned acc_width(input int unsigned sample_w,
                                              input int unsigned window);
        return sample_w + $clog2(window);
    endfunction

    function automatic int unsigned shot_len(input int unsigned window,
                                             input int unsigned num_bins);
        return window * num_bins;
    endfunction

    function automatic int unsigned feat_offset(input int unsigned k,
                                                input int unsigned in_bits);
        return k * in_bits;
    endfunction

endpackage

// File: rtl/readout_feature_quantizer_if.sv
// readout_feature_quantizer_if: sample stream in, feature vector out, error pulses.
//   s_valid/s_ready/s_i/s_q/s_last : signed I/Q sample stream with shot framing
//   m_valid/m_ready/m_data         : packed quantized feature vector
//   err_short/err_long             : one-cycle malformed-shot pulses
// Modports: master = stream source / feature sink, slave = the quantizer.
interface readout_feature_quantizer_if #(
    parameter int unsigned SAMPLE_W = 12,
    parameter int unsigned NUM_BINS = 4,
    parameter int unsigned IN_BITS  = 2
);
    logic                                s_valid;
    logic                                s_ready;
    logic signed [SAMPLE_W-1:0]          s_i;
    logic signed [SAMPLE_W-1:0]          s_q;
    logic                                s_last;
    logic                                m_valid;
    logic                                m_ready;
    logic [2*NUM_BINS*IN_BITS-1:0]       m_data;
    logic                                err_short;
    logic                                err_long;

    modport master (
        output s_valid, s_i, s_q, s_last, m_ready,
        input  s_ready, m_valid, m_data, err_short, err_long
    );

    modport slave (
        input  s_valid, s_i, s_q, s_last, m_ready,
        output s_ready, m_valid, m_data, err_short, err_long
    );
endinterface

// File: rtl/readout_feature_quantizer_quant_sat.sv
// quant_sat: quantizes one bin sum to an IN_BITS unsigned code.
//   sum  : signed bin sum (ACC_W bits)
//   code : clamp((sum >>> SHIFT) + 2^(IN_BITS-1), 0, 2^IN_BITS-1)
// Build option QUANT_ROUND_EN: adds 2^(SHIFT-1) before the shift (round half up);
// otherwise the shift truncates toward minus infinity.
module quant_sat #(
    parameter int unsigned ACC_W   = 15,
    parameter int unsigned IN_BITS = 2,
    parameter int unsigned SHIFT   = 12
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic [IN_BITS-1:0]      code
);
    // Two guard bits keep the rounding add and the offset add from overflowing.
    localparam int unsigned W = ((ACC_W > SHIFT) ? ACC_W : SHIFT) + 2;
    localparam logic signed [W-1:0] OFFSET   = W'(1) << (IN_BITS - 1);
    localparam logic signed [W-1:0] MAX_CODE = W'((1 << IN_BITS) - 1);

    logic signed [W-1:0] ext;
    logic signed [W-1:0] rnd;
    logic signed [W-1:0] shifted;
    logic signed [W-1:0] biased;

    assign ext = W'(sum);

`ifdef QUANT_ROUND_EN
    localparam logic signed [W-1:0] HALF = W'(1) << (SHIFT - 1);
    assign rnd = ext + HALF;
`else
    assign rnd = ext;
`endif

    assign shifted = rnd >>> SHIFT;
    assign biased  = shifted + OFFSET;

    always_comb begin
        code = biased[IN_BITS-1:0];
        if (biased[W-1]) begin
            code = '0;
        end else if (biased > MAX_CODE) begin
            code = '1;
        end
    end
endmodule

// File: rtl/readout_feature_quantizer.sv
// readout_feature_quantizer: integrates one readout shot of I/Q samples into NUM_BINS
// bins, quantizes the 2*NUM_BINS sums and presents them as one packed word.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : readout_feature_quantizer_if.slave (sample stream, feature output,
//                err_short / err_long pulses)
// Build option QUANT_ROUND_EN (inside quant_sat) selects round-half-up quantization.
module readout_feature_quantizer
    import readout_quant_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 12,
    parameter int unsigned WINDOW   = 8,
    parameter int unsigned NUM_BINS = 4,
    parameter int unsigned IN_BITS  = 2,
    parameter int unsigned SHIFT    = 12
) (
    input logic                          clk,
    input logic                          rst_n,
    readout_feature_quantizer_if.slave   bus
);
    localparam int unsigned ACC_W    = acc_width(SAMPLE_W, WINDOW);
    localparam int unsigned SHOT_LEN = shot_len(WINDOW, NUM_BINS);
    localparam int unsigned CNT_W    = $clog2(SHOT_LEN);
    localparam int unsigned LOG_WIN  = $clog2(WINDOW);
    localparam int unsigned BIN_W    = $clog2(NUM_BINS);
    localparam int unsigned NUM_FEAT = 2 * NUM_BINS;
    localparam int unsigned DATA_W   = NUM_FEAT * IN_BITS;

    logic [1:0]               state_q, state_d;
    logic                     drain_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [BIN_W-1:0]         bin;
    logic signed [ACC_W-1:0]  acc_i_q [NUM_BINS];
    logic signed [ACC_W-1:0]  acc_q_q [NUM_BINS];
    logic                     s_ready_q;
    logic                     m_valid_q;
    logic [DATA_W-1:0]        m_data_q;
    logic                     err_short_q;
    logic                     err_long_q;
    logic                     accept;
    logic                     shot_end;
    logic [DATA_W-1:0]        codes_packed;

    // WINDOW is a power of two, so the bin index is the upper counter bits.
    assign bin      = BIN_W'(cnt_q >> LOG_WIN);
    assign accept   = bus.s_valid && s_ready_q;
    assign shot_end = (cnt_q == CNT_W'(SHOT_LEN - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            StAccum: if (accept && shot_end) state_d = StQuant;
            StQuant: state_d = StHold;
            StHold:  if (bus.m_ready) state_d = drain_q ? StDrain : StAccum;
            StDrain: if (accept && bus.s_last) state_d = StAccum;
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StAccum;
            drain_q     <= 1'b0;
            cnt_q       <= '0;
            s_ready_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            for (int b = 0; b < NUM_BINS; b++) begin
                acc_i_q[b] <= '0;
                acc_q_q[b] <= '0;
            end
        end else begin
            state_q     <= state_d;
            // Registered from the next state so s_ready stays low during reset.
            s_ready_q   <= (state_d == StAccum) || (state_d == StDrain);
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            case (state_q)
                StAccum: begin
                    if (accept) begin
                        acc_i_q[bin] <= acc_i_q[bin] + ACC_W'(bus.s_i);
                        acc_q_q[bin] <= acc_q_q[bin] + ACC_W'(bus.s_q);
                        cnt_q        <= cnt_q + 1'b1;
                        if (shot_end) begin
                            cnt_q      <= '0;
                            drain_q    <= !bus.s_last;
                            err_long_q <= !bus.s_last;
                        end else if (bus.s_last) begin
                            // Early s_last: drop the partial frame, overriding the add.
                            err_short_q <= 1'b1;
                            cnt_q       <= '0;
                            for (int b = 0; b < NUM_BINS; b++) begin
                                acc_i_q[b] <= '0;
                                acc_q_q[b] <= '0;
                            end
                        end
                    end
                end
                StQuant: begin
                    m_data_q  <= codes_packed;
                    m_valid_q <= 1'b1;
                end
                StHold: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        for (int b = 0; b < NUM_BINS; b++) begin
                            acc_i_q[b] <= '0;
                            acc_q_q[b] <= '0;
                        end
                    end
                end
                StDrain: begin
                    if (accept && bus.s_last) drain_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_FEAT; k++) begin : g_feat
        logic signed [ACC_W-1:0] feat_sum;
        logic [IN_BITS-1:0]      feat_code;

        // Even features carry I, odd features carry Q of bin k/2.
        assign feat_sum = (k % 2 == 0) ? acc_i_q[k / 2] : acc_q_q[k / 2];

        quant_sat #(
            .ACC_W   (ACC_W),
            .IN_BITS (IN_BITS),
            .SHIFT   (SHIFT)
        ) u_quant_sat (
            .sum  (feat_sum),
            .code (feat_code)
        );

        assign codes_packed[feat_offset(k, IN_BITS) +: IN_BITS] = feat_code;
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_data    = m_data_q;
    assign bus.err_short = err_short_q;
    assign bus.err_long  = err_long_q;
endmodule

// File: tb/tb_readout_feature_quantizer.sv
// Bench for readout_feature_quantizer: constant-shot vector table, random shots against a
// bin-sum reference model, and hand-written backpressure / short / long / reset sequences.
module tb_readout_feature_quantizer;
    localparam int SAMPLE_W = 12;
    localparam int WINDOW   = 8;
    localparam int NUM_BINS = 4;
    localparam int IN_BITS  = 2;
    localparam int SHIFT    = 12;
    localparam int SHOT     = WINDOW * NUM_BINS;
    localparam int DATA_W   = 2 * NUM_BINS * IN_BITS;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    readout_feature_quantizer_if #(
        .SAMPLE_W (SAMPLE_W),
        .NUM_BINS (NUM_BINS),
        .IN_BITS  (IN_BITS)
    ) bus ();

    readout_feature_quantizer #(
        .SAMPLE_W (SAMPLE_W),
        .WINDOW   (WINDOW),
        .NUM_BINS (NUM_BINS),
        .IN_BITS  (IN_BITS),
        .SHIFT    (SHIFT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- output monitor (samples on the falling edge) ----------------
    logic [DATA_W-1:0] got_q[$];
    int n_short = 0, n_long = 0, err_long_cyc = 0, valid_rise_cyc = 0;
    int valid_len = 0, cur_len = 0;
    logic prev_valid = 1'b0, prev_hs = 1'b0, prev_short = 1'b0, prev_long = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
            prev_short = 1'b0;
            prev_long  = 1'b0;
            cur_len    = 0;
        end else begin
            if (bus.err_short) begin
                n_short++;
                check("err_short_width", prev_short, 0);
            end
            if (bus.err_long) begin
                n_long++;
                err_long_cyc = cyc;
                check("err_long_width", prev_long, 0);
            end
            if (bus.m_valid) begin
                if (!prev_valid || prev_hs) begin
                    valid_rise_cyc = cyc;
                    cur_len = 0;
                end else begin
                    check("hold_stable", bus.m_data, prev_data);
                end
                check("s_ready_in_hold", bus.s_ready, 0);
                cur_len++;
                if (bus.m_ready) begin
                    got_q.push_back(bus.m_data);
                    valid_len = cur_len;
                end
            end
            prev_valid = bus.m_valid;
            prev_hs    = bus.m_valid && bus.m_ready;
            prev_data  = bus.m_data;
            prev_short = bus.err_short;
            prev_long  = bus.err_long;
        end
    end

    // ---------------- reference model ----------------
    int shot_i[$];
    int shot_q[$];
    int acc_at[64];

    function automatic int qcode(input int sum);
        int v;
        int f;
        v = sum;
`ifdef QUANT_ROUND_EN
        v = v + (1 << (SHIFT - 1));
`endif
        f = (v >= 0) ? v / (1 << SHIFT) : -((-v + (1 << SHIFT) - 1) / (1 << SHIFT));
        f = f + (1 << (IN_BITS - 1));
        if (f < 0) f = 0;
        if (f > (1 << IN_BITS) - 1) f = (1 << IN_BITS) - 1;
        return f;
    endfunction

    function automatic logic [DATA_W-1:0] model();
        logic [DATA_W-1:0] d;
        int si;
        int sq;
        d = '0;
        for (int b = 0; b < NUM_BINS; b++) begin
            si = 0;
            sq = 0;
            for (int w = 0; w < WINDOW; w++) begin
                si += shot_i[b * WINDOW + w];
                sq += shot_q[b * WINDOW + w];
            end
            d |= DATA_W'(qcode(si)) << (2 * b * IN_BITS);
            d |= DATA_W'(qcode(sq)) << ((2 * b + 1) * IN_BITS);
        end
        return d;
    endfunction

    // ---------------- drivers ----------------
    task automatic send(input int iv, input int qv, input bit last, output int acc_cyc);
        int b;
        b = 0;
        bus.s_valid = 1'b1;
        bus.s_i     = SAMPLE_W'(iv);
        bus.s_q     = SAMPLE_W'(qv);
        bus.s_last  = last;
        while (bus.s_ready !== 1'b1 && b < 200) begin
            @(posedge clk);
            #1;
            b++;
        end
        check("s_ready_wait", b < 200, 1);
        @(posedge clk);
        #1;
        acc_cyc     = cyc;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic run_shot(input int n, input int last_at);
        int c;
        for (int k = 0; k < n; k++) begin
            send(shot_i[k], shot_q[k], (k + 1) == last_at, c);
            acc_at[k] = c;
        end
    endtask

    task automatic fill_const(input int n, input int iv, input int qv);
        shot_i.delete();
        shot_q.delete();
        for (int k = 0; k < n; k++) begin
            shot_i.push_back(iv);
            shot_q.push_back(qv);
        end
    endtask

    task automatic wait_out(output logic [DATA_W-1:0] d);
        int b;
        b = 0;
        while (got_q.size() == 0 && b < 300) begin
            @(posedge clk);
            #1;
            b++;
        end
        check("out_wait", got_q.size() > 0, 1);
        d = (got_q.size() > 0) ? got_q.pop_front() : 'x;
    endtask

    task automatic wait_valid();
        int b;
        b = 0;
        while (bus.m_valid !== 1'b1 && b < 100) begin
            @(posedge clk);
            #1;
            b++;
        end
        check("valid_wait", b < 100, 1);
    endtask

    task automatic nominal_shot(input string name);
        logic [DATA_W-1:0] d;
        fill_const(SHOT, 512, -512);
        run_shot(SHOT, SHOT);
        wait_out(d);
        check(name, d, 16'h7777);
    endtask

    typedef struct {
        int                iv;
        int                qv;
        logic [DATA_W-1:0] exp;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] d;
        int base_s, base_l;

        vecs[0] = '{512, -512, 16'h7777};
        vecs[1] = '{2047, -2048, 16'h3333};
        vecs[2] = '{-2048, 2047, 16'hCCCC};
        vecs[3] = '{0, 0, 16'hAAAA};
`ifdef QUANT_ROUND_EN
        vecs[4] = '{256, 0, 16'hBBBB};
        vecs[5] = '{-1, -1, 16'hAAAA};
`else
        vecs[4] = '{256, 0, 16'hAAAA};
        vecs[5] = '{-1, -1, 16'h5555};
`endif

        bus.s_valid = 1'b0;
        bus.s_i     = '0;
        bus.s_q     = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_err_short", bus.err_short, 0);
        check("rst_err_long", bus.err_long, 0);
        check("rst_s_ready", bus.s_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("s_ready_after_rst", bus.s_ready, 1);

        // Constant-valued shots from the table, m_ready held high.
        for (int v = 0; v < 6; v++) begin
            base_s = n_short;
            base_l = n_long;
            fill_const(SHOT, vecs[v].iv, vecs[v].qv);
            run_shot(SHOT, SHOT);
            wait_out(d);
            check("vec_data", d, vecs[v].exp);
            check("vec_model", d, model());
            check("vec_latency", valid_rise_cyc - acc_at[SHOT - 1], 1);
            check("vec_valid_len", valid_len, 1);
            check("vec_no_err", (n_short - base_s) + (n_long - base_l), 0);
        end

        // Random shots with random downstream stall.
        for (int r = 0; r < 8; r++) begin
            shot_i.delete();
            shot_q.delete();
            for (int k = 0; k < SHOT; k++) begin
                if (r % 2 == 0) begin
                    shot_i.push_back(int'($urandom_range(4095)) - 2048);
                    shot_q.push_back(int'($urandom_range(4095)) - 2048);
                end else begin
                    shot_i.push_back(int'($urandom_range(1023)) - 512);
                    shot_q.push_back(int'($urandom_range(1023)) - 512);
                end
            end
            bus.m_ready = 1'b0;
            run_shot(SHOT, SHOT);
            wait_valid();
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            bus.m_ready = 1'b1;
            wait_out(d);
            check("rand_model", d, model());
        end

        // Backpressure: m_ready low for 10 cycles after m_valid.
        bus.m_ready = 1'b0;
        fill_const(SHOT, 512, -512);
        run_shot(SHOT, SHOT);
        wait_valid();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp_valid_held", bus.m_valid, 1);
            check("bp_s_ready_low", bus.s_ready, 0);
            check("bp_data", bus.m_data, 16'h7777);
        end
        bus.m_ready = 1'b1;
        wait_out(d);
        check("bp_out", d, 16'h7777);
        check("bp_ready_back", bus.s_ready, 1);
        nominal_shot("bp_next_shot");

        // Short shot: s_last on sample 20, frame discarded.
        base_s = n_short;
        fill_const(20, 2047, 2047);
        run_shot(20, 20);
        repeat (5) @(posedge clk);
        #1;
        check("short_err_count", n_short - base_s, 1);
        check("short_no_out", got_q.size(), 0);
        check("short_no_valid", bus.m_valid, 0);
        nominal_shot("short_next_shot");

        // Long shot: 40 samples, frame from the first 32, tail dropped.
        base_s = n_short;
        base_l = n_long;
        fill_const(SHOT, 512, -512);
        for (int k = 0; k < 8; k++) begin
            shot_i.push_back(2047);
            shot_q.push_back(2047);
        end
        run_shot(40, 40);
        check("long_err_count", n_long - base_l, 1);
        check("long_err_at_32", err_long_cyc, acc_at[SHOT - 1]);
        check("long_latency", valid_rise_cyc - acc_at[SHOT - 1], 1);
        wait_out(d);
        check("long_out", d, 16'h7777);
        repeat (5) @(posedge clk);
        #1;
        check("long_single_frame", got_q.size(), 0);
        check("long_no_short", n_short - base_s, 0);
        nominal_shot("long_next_shot");

        // Reset in the middle of a shot.
        base_s = n_short;
        base_l = n_long;
        fill_const(15, 2047, 2047);
        run_shot(15, 0);
        rst_n = 1'b0;
        #2;
        check("mid_rst_m_data", bus.m_data, 0);
        check("mid_rst_m_valid", bus.m_valid, 0);
        check("mid_rst_s_ready", bus.s_ready, 0);
        check("mid_rst_err", {bus.err_short, bus.err_long}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_ready_back", bus.s_ready, 1);
        nominal_shot("mid_rst_next_shot");
        check("mid_rst_no_err", (n_short - base_s) + (n_long - base_l), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
